// File: rtl/link_pkg.sv
// Shared constants and types for the single-wire word link.
// Used by both the transmitter and the receiver.
package link_pkg;

  localparam int LINK_WORD_W = 32;
  localparam int LINK_FRAME_LEN = 33;
  localparam logic LINK_START_BIT = 1'b1;

  localparam int LINK_CNT_W = 5;
  localparam logic [LINK_CNT_W-1:0] LINK_LAST_BIT = 5'd31;

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } rx_state_t;

endpackage

// File: rtl/receiver.sv
// Serial-to-parallel receiver: start bit, 32 bits MSB first, valid/ready out.
// Ports: clk, res (sync active-high), d_rc (line), dout/validout/readyout;
// overrun/overrun_clr exist only when RECEIVER_OVERRUN_EN is defined.
module receiver
  import link_pkg::*;
(
  input  logic                   clk,
  input  logic                   res,
  input  logic                   d_rc,
  output logic [LINK_WORD_W-1:0] dout,
  output logic                   validout,
  input  logic                   readyout
`ifdef RECEIVER_OVERRUN_EN
  ,
  output logic                   overrun,
  input  logic                   overrun_clr
`endif
);

  rx_state_t              state_q;
  logic [LINK_CNT_W-1:0]  bitcnt_q;
  logic [LINK_WORD_W-2:0] shreg_q;
  logic [LINK_WORD_W-1:0] dout_q;
  logic                   valid_q;

  logic                   done;
  logic                   accept;
  logic                   load;
  logic [LINK_WORD_W-1:0] word_d;

  // The last data bit is taken straight from the line, so the
  // shifter only needs to hold the 31 bits seen before it.
  assign done   = (state_q == RX_SHIFT) && (bitcnt_q == LINK_LAST_BIT);
  assign word_d = {shreg_q, d_rc};
  assign accept = valid_q && readyout;
  assign load   = done && (!valid_q || accept);

  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= RX_IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        RX_IDLE: begin
          if (d_rc == LINK_START_BIT) begin
            state_q  <= RX_SHIFT;
            bitcnt_q <= '0;
          end
        end
        RX_SHIFT: begin
          shreg_q  <= {shreg_q[LINK_WORD_W-3:0], d_rc};
          bitcnt_q <= bitcnt_q + 1'b1;
          if (bitcnt_q == LINK_LAST_BIT) begin
            state_q <= RX_IDLE;
          end
        end
        default: state_q <= RX_IDLE;
      endcase

      // A completed word replaces the held one only if the held one
      // is gone or leaves this cycle; otherwise the new word is lost.
      if (load) begin
        dout_q  <= word_d;
        valid_q <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign dout     = dout_q;
  assign validout = valid_q;

`ifdef RECEIVER_OVERRUN_EN
  logic ovf_q;
  logic ovf_ev;

  assign ovf_ev = done && valid_q && !readyout;

  // Setting beats clearing so an event is never hidden by a clear.
  always_ff @(posedge clk) begin
    if (res) begin
      ovf_q <= 1'b0;
    end else if (ovf_ev) begin
      ovf_q <= 1'b1;
    end else if (overrun_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign overrun = ovf_q;
`endif

endmodule

// File: tb/tb_receiver.sv
// Randomized and directed bench for the link receiver.
// Frame schedule drives a word-level reference model.
module tb_receiver;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        d_rc = 1'b0;
  logic [31:0] dout;
  logic        validout;
  logic        readyout = 1'b0;
  logic        overrun_clr = 1'b0;
  logic        overrun;

  always #5 clk = ~clk;

  receiver dut (
    .clk        (clk),
    .res        (res),
    .d_rc       (d_rc),
    .dout       (dout),
    .validout   (validout),
    .readyout   (readyout)
`ifdef RECEIVER_OVERRUN_EN
    ,
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
`endif
  );

`ifndef RECEIVER_OVERRUN_EN
  assign overrun = 1'b0;
`endif

  int n_chk = 0;
  int n_pass = 0;
  bit started = 0;

  // Word-level model fed by the driver's frame schedule.
  bit          m_done = 0;
  logic [31:0] m_word = '0;
  bit          mv = 0;
  logic [31:0] md = '0;
  bit          mo = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endfunction

  always @(posedge clk) begin
    bit acc;
    bit ev;
    ev = 0;
    if (res) begin
      mv = 0;
      md = '0;
      mo = 0;
    end else begin
      acc = mv && readyout;
      if (m_done) begin
        if (!mv || acc) begin
          md = m_word;
          mv = 1;
        end else begin
          ev = 1;
        end
      end else if (acc) begin
        mv = 0;
      end
      if (ev) mo = 1;
      else if (overrun_clr) mo = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("validout", {31'd0, validout}, {31'd0, mv});
      chk("dout", dout, md);
`ifdef RECEIVER_OVERRUN_EN
      chk("overrun", {31'd0, overrun}, {31'd0, mo});
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rmode: 0 hold off, 1 always ready, 2 random, 3 ready only on last bit
  task automatic send_frame(input logic [31:0] w, input int rmode);
    for (int i = 0; i <= 32; i++) begin
      d_rc = (i == 0) ? 1'b1 : w[32-i];
      m_done = (i == 32);
      m_word = w;
      case (rmode)
        0: readyout = 1'b0;
        1: readyout = 1'b1;
        2: readyout = ($urandom_range(0, 3) != 0);
        default: readyout = (i == 32);
      endcase
      tick();
    end
    m_done = 0;
    d_rc = 1'b0;
  endtask

  task automatic abort_frame(input logic [31:0] w, input int nbits);
    readyout = 1'b1;
    for (int i = 0; i <= nbits; i++) begin
      d_rc = (i == 0) ? 1'b1 : w[32-i];
      tick();
    end
    d_rc = 1'b0;
    res = 1'b1;
    tick();
    tick();
    res = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    res = 1'b1;
    tick();
    tick();
    started = 1;
    res = 1'b0;

    // Idle line: no false start.
    idle(50);
    chk("idle_valid", {31'd0, validout}, 32'd0);
    chk("idle_dout", dout, 32'd0);

    // Single frame, one-cycle valid pulse.
    readyout = 1'b1;
    send_frame(32'hA5A5_0F0F, 1);
    chk("single_valid", {31'd0, validout}, 32'd1);
    chk("single_dout", dout, 32'hA5A5_0F0F);
    tick();
    chk("single_pulse", {31'd0, validout}, 32'd0);
    idle(3);

    // Back-to-back frames.
    send_frame(32'hFFFF_FFFF, 1);
    chk("b2b_first", dout, 32'hFFFF_FFFF);
    send_frame(32'h0000_0001, 1);
    chk("b2b_second", dout, 32'h0000_0001);
    chk("b2b_valid", {31'd0, validout}, 32'd1);
    tick();
    idle(3);

    // Consumer stalls across two frames.
    send_frame(32'h1234_5678, 0);
    send_frame(32'h9ABC_DEF0, 0);
    chk("stall_dout", dout, 32'h1234_5678);
    chk("stall_valid", {31'd0, validout}, 32'd1);
`ifdef RECEIVER_OVERRUN_EN
    chk("ovf_set", {31'd0, overrun}, 32'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovf_clr", {31'd0, overrun}, 32'd0);
`endif
    readyout = 1'b1;
    tick();
    chk("stall_drain", {31'd0, validout}, 32'd0);
    idle(2);

    // Accept exactly as the second frame completes.
    send_frame(32'h1111_2222, 0);
    send_frame(32'h3333_4444, 3);
    chk("edge_dout", dout, 32'h3333_4444);
    chk("edge_valid", {31'd0, validout}, 32'd1);
`ifdef RECEIVER_OVERRUN_EN
    chk("edge_no_ovf", {31'd0, overrun}, 32'd0);
`endif
    readyout = 1'b1;
    tick();
    idle(2);

    // Reset mid-frame, then a clean frame.
    abort_frame(32'hDEAD_BEEF, 16);
    idle(3);
    chk("abort_valid", {31'd0, validout}, 32'd0);
    chk("abort_dout", dout, 32'd0);
    send_frame(32'h8000_0000, 1);
    chk("post_abort", dout, 32'h8000_0000);
    tick();

    // Randomized traffic.
    for (int f = 0; f < 40; f++) begin
      send_frame($urandom, 2);
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        readyout = ($urandom_range(0, 1) != 0);
        overrun_clr = ($urandom_range(0, 4) == 0);
        tick();
      end
      overrun_clr = 1'b0;
    end
    readyout = 1'b1;
    idle(4);

    started = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
